// File: rtl/gtx_tx_pkg.sv
// Shared constants, state type and CRC step for the GTX transmit scheduler.
package gtx_tx_pkg;

    localparam logic [15:0] K_COMMA  = 16'hbcbc;
    localparam logic [15:0] K_IDLE   = 16'h1c1c;
    localparam logic [7:0]  K_SOF_HI = 8'hfb;
    localparam logic [15:0] K_EOF    = 16'hfdfd;

    localparam logic [1:0] CTRL_KK = 2'b11;
    localparam logic [1:0] CTRL_KD = 2'b10;
    localparam logic [1:0] CTRL_DD = 2'b00;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hffff;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        CRC,
        EOF
    } tx_state_e;

    // CRC-16-CCITT over one 16-bit word, MSB first
    function automatic logic [15:0] crc16_step(input logic [15:0] crc,
                                               input logic [15:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ d[i]) c = (c << 1) ^ CRC_POLY;
            else              c = c << 1;
        end
        return c;
    endfunction

endpackage

// File: rtl/gtx_tx_sched_crc16.sv
// Per-packet CRC-16-CCITT accumulator, one payload word per cycle.
module gtx_tx_crc16
    import gtx_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [15:0] data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else if (clr_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc16_step(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gtx_tx_sched.sv
// Two-requester round-robin packet scheduler driving GTX TXDATA/TXCHARISK.
// Optional trailing CRC word per packet when GTX_TX_SCHED_CRC_EN is defined.
module gtx_tx_sched
    import gtx_tx_pkg::*;
#(
    parameter int COMMA_PERIOD = 16,
    parameter int CNT_W        = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] s0_data_i,
    input  logic        s0_valid_i,
    input  logic        s0_last_i,
    output logic        s0_ready_o,
    input  logic [15:0] s1_data_i,
    input  logic        s1_valid_i,
    input  logic        s1_last_i,
    output logic        s1_ready_o,
    output logic [1:0]  ctrl_o,
    output logic [15:0] data_o,
    output logic        busy_o,
    output logic        grant_o
);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      data_q;
    logic [1:0]       ctrl_q;
    logic             busy_q;
    logic             grant_q;
    logic             ptr_q;
    logic             cont_q;

    logic        comma;
    logic        any_v;
    logic        both_v;
    logic        sel;
    logic        g_valid;
    logic        g_last;
    logic [15:0] g_data;
    logic        take;
    logic [15:0] crc;

    assign comma   = (cnt_q == '0);
    assign any_v   = s0_valid_i | s1_valid_i;
    assign both_v  = s0_valid_i & s1_valid_i;
    assign sel     = both_v ? ptr_q : s1_valid_i;
    assign g_valid = grant_q ? s1_valid_i : s0_valid_i;
    assign g_last  = grant_q ? s1_last_i  : s0_last_i;
    assign g_data  = grant_q ? s1_data_i  : s0_data_i;

    assign s0_ready_o = (state_q == DATA) && !grant_q && !comma;
    assign s1_ready_o = (state_q == DATA) &&  grant_q && !comma;
    assign take       = (state_q == DATA) && !comma && g_valid;

`ifdef GTX_TX_SCHED_CRC_EN
    localparam tx_state_e AFTER_LAST = CRC;
    logic crc_clr;

    assign crc_clr = (state_q == IDLE) && !comma && any_v;

    gtx_tx_crc16 u_crc (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .clr_i  (crc_clr),
        .en_i   (take),
        .data_i (g_data),
        .crc_o  (crc)
    );
`else
    localparam tx_state_e AFTER_LAST = EOF;

    assign crc = K_IDLE;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= 16'h0000;
            ctrl_q  <= 2'b00;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            ptr_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == CNT_W'(COMMA_PERIOD - 1)) ? '0 : cnt_q + 1'b1;
            if (comma) begin
                data_q <= K_COMMA;
                ctrl_q <= CTRL_KK;
                busy_q <= (state_q != IDLE);
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (any_v) begin
                            grant_q <= sel;
                            cont_q  <= both_v;
                            data_q  <= {K_SOF_HI, 7'h00, sel};
                            ctrl_q  <= CTRL_KD;
                            busy_q  <= 1'b1;
                            state_q <= DATA;
                        end else begin
                            data_q <= K_IDLE;
                            ctrl_q <= CTRL_KK;
                            busy_q <= 1'b0;
                        end
                    end
                    DATA: begin
                        busy_q <= 1'b1;
                        if (g_valid) begin
                            data_q <= g_data;
                            ctrl_q <= CTRL_DD;
                            if (g_last) state_q <= AFTER_LAST;
                        end else begin
                            data_q <= K_IDLE;
                            ctrl_q <= CTRL_KK;
                        end
                    end
                    CRC: begin
                        data_q  <= crc;
                        ctrl_q  <= CTRL_DD;
                        busy_q  <= 1'b1;
                        state_q <= EOF;
                    end
                    EOF: begin
                        data_q  <= K_EOF;
                        ctrl_q  <= CTRL_KK;
                        busy_q  <= 1'b1;
                        // only contended grants rotate the pointer
                        if (cont_q) ptr_q <= ~grant_q;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;
    assign busy_o  = busy_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_gtx_tx_sched.sv
// Directed bench for gtx_tx_sched: framing, commas, arbitration, underrun, reset.
module tb_gtx_tx_sched;

    localparam logic [1:0] KK = 2'b11;
    localparam logic [1:0] KD = 2'b10;
    localparam logic [1:0] DD = 2'b00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] s0_data = '0;
    logic        s0_valid = 1'b0;
    logic        s0_last = 1'b0;
    logic        s0_ready;
    logic [15:0] s1_data = '0;
    logic        s1_valid = 1'b0;
    logic        s1_last = 1'b0;
    logic        s1_ready;
    logic [1:0]  ctrl;
    logic [15:0] data;
    logic        busy;
    logic        grant;

    always #5 clk = ~clk;

    gtx_tx_sched #(
        .COMMA_PERIOD(16),
        .CNT_W       (8)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .s0_data_i (s0_data),
        .s0_valid_i(s0_valid),
        .s0_last_i (s0_last),
        .s0_ready_o(s0_ready),
        .s1_data_i (s1_data),
        .s1_valid_i(s1_valid),
        .s1_last_i (s1_last),
        .s1_ready_o(s1_ready),
        .ctrl_o    (ctrl),
        .data_o    (data),
        .busy_o    (busy),
        .grant_o   (grant)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          slot = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    int          idx0 = 0;
    int          idx1 = 0;
    int          gap_at0 = -1;
    int          gap_len0 = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic b, input logic g,
                                       input logic [1:0] c,
                                       input logic [15:0] d);
        return {12'h000, b, g, c, d};
    endfunction

    function automatic logic [31:0] obs();
        return {12'h000, busy, grant, ctrl, data};
    endfunction

    function automatic logic [31:0] rdy();
        return {30'h0, s0_ready, s1_ready};
    endfunction

    task automatic drive();
        logic g0;
        g0 = (idx0 == gap_at0) && (gap_len0 > 0);
        s0_valid = (idx0 < q0.size()) && !g0;
        s0_data  = s0_valid ? q0[idx0] : 16'h0000;
        s0_last  = s0_valid && (idx0 == q0.size() - 1);
        s1_valid = (idx1 < q1.size());
        s1_data  = s1_valid ? q1[idx1] : 16'h0000;
        s1_last  = s1_valid && (idx1 == q1.size() - 1);
    endtask

    task automatic step();
        logic f0;
        logic f1;
        logic g0;
        f0 = s0_valid & s0_ready;
        f1 = s1_valid & s1_ready;
        g0 = (idx0 == gap_at0) && (gap_len0 > 0);
        @(posedge clk);
        #1;
        slot = (slot + 1) % 16;
        if (f0) idx0++;
        if (f1) idx1++;
        if (g0) gap_len0--;
        drive();
    endtask

    task automatic run(input string tag, input logic [31:0] exp);
        step();
        check(tag, obs(), exp);
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        idx0 = 0;
        idx1 = 0;
        gap_at0 = -1;
        gap_len0 = 0;
    endtask

    initial begin
        #12;
        check("rst_out", obs(), 32'h0);
        check("rst_rdy", rdy(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        slot = 0;

        // idle stream with commas every 16 words
        for (int i = 0; i < 32; i++) begin
            if (i % 16 == 0) run("idle_comma", pk(0, 0, KK, 16'hbcbc));
            else             run("idle_fill", pk(0, 0, KK, 16'h1c1c));
        end
        check("idle_rdy", rdy(), 32'h0);
        run("comma2", pk(0, 0, KK, 16'hbcbc));

        // s0 three-word packet in slots 1..5
        clear_q();
        q0 = '{16'h1111, 16'h2222, 16'h3333};
        drive();
        run("p3_sof", pk(1, 0, KD, 16'hfb00));
        check("p3_rdy", rdy(), 32'h2);
        run("p3_w0", pk(1, 0, DD, 16'h1111));
        run("p3_w1", pk(1, 0, DD, 16'h2222));
        run("p3_w2", pk(1, 0, DD, 16'h3333));
        run("p3_eof", pk(1, 0, KK, 16'hfdfd));
        run("p3_idle", pk(0, 0, KK, 16'h1c1c));

        // contention: s0 first, s1 alone keeps the pointer at s1
        clear_q();
        q0 = '{16'ha001, 16'ha002};
        q1 = '{16'hb001, 16'hb002};
        drive();
        run("c_sof0", pk(1, 0, KD, 16'hfb00));
        run("c_a1", pk(1, 0, DD, 16'ha001));
        run("c_a2", pk(1, 0, DD, 16'ha002));
        run("c_eof0", pk(1, 0, KK, 16'hfdfd));
        run("c_sof1", pk(1, 1, KD, 16'hfb01));
        run("c_b1", pk(1, 1, DD, 16'hb001));
        run("c_b2", pk(1, 1, DD, 16'hb002));
        run("c_eof1", pk(1, 1, KK, 16'hfdfd));
        run("c_idle", pk(0, 1, KK, 16'h1c1c));
        run("c_comma", pk(0, 1, KK, 16'hbcbc));

        clear_q();
        q0 = '{16'hc001};
        q1 = '{16'hd001};
        drive();
        run("c2_sof1", pk(1, 1, KD, 16'hfb01));
        run("c2_d1", pk(1, 1, DD, 16'hd001));
        run("c2_eof1", pk(1, 1, KK, 16'hfdfd));
        run("c2_sof0", pk(1, 0, KD, 16'hfb00));
        run("c2_c1", pk(1, 0, DD, 16'hc001));
        run("c2_eof0", pk(1, 0, KK, 16'hfdfd));
        run("c2_idle", pk(0, 0, KK, 16'h1c1c));

        // packet straddling the comma slot
        clear_q();
        drive();
        for (int i = 0; i < 5; i++) run("s_pre", pk(0, 0, KK, 16'h1c1c));
        q0 = '{16'he001, 16'he002, 16'he003, 16'he004, 16'he005};
        drive();
        run("s_sof", pk(1, 0, KD, 16'hfb00));
        run("s_w1", pk(1, 0, DD, 16'he001));
        run("s_w2", pk(1, 0, DD, 16'he002));
        check("s_rdy_comma", rdy(), 32'h0);
        run("s_comma", pk(1, 0, KK, 16'hbcbc));
        check("s_rdy_resume", rdy(), 32'h2);
        run("s_w3", pk(1, 0, DD, 16'he003));
        run("s_w4", pk(1, 0, DD, 16'he004));
        run("s_w5", pk(1, 0, DD, 16'he005));
        run("s_eof", pk(1, 0, KK, 16'hfdfd));
        run("s_idle", pk(0, 0, KK, 16'h1c1c));

        // underrun for two cycles, then reset mid-packet
        clear_q();
        q0 = '{16'hf001, 16'hf002, 16'hf003, 16'hf004};
        gap_at0 = 1;
        gap_len0 = 2;
        drive();
        run("u_sof", pk(1, 0, KD, 16'hfb00));
        run("u_w1", pk(1, 0, DD, 16'hf001));
        check("u_rdy_novalid", rdy(), 32'h2);
        run("u_fill1", pk(1, 0, KK, 16'h1c1c));
        run("u_fill2", pk(1, 0, KK, 16'h1c1c));
        run("u_w2", pk(1, 0, DD, 16'hf002));
        run("u_w3", pk(1, 0, DD, 16'hf003));
        rst_n = 1'b0;
        #2;
        check("r_out", obs(), 32'h0);
        check("r_rdy", rdy(), 32'h0);
        clear_q();
        drive();
        @(negedge clk);
        rst_n = 1'b1;
        slot = 0;
        run("r_comma", pk(0, 0, KK, 16'hbcbc));
        run("r_idle", pk(0, 0, KK, 16'h1c1c));

        // single-word packet of 0x0000
        q0 = '{16'h0000};
        drive();
        run("z_sof", pk(1, 0, KD, 16'hfb00));
        run("z_w", pk(1, 0, DD, 16'h0000));
`ifdef GTX_TX_SCHED_CRC_EN
        run("z_crc", pk(1, 0, DD, 16'h1d0f));
`endif
        run("z_eof", pk(1, 0, KK, 16'hfdfd));
        run("z_idle", pk(0, 0, KK, 16'h1c1c));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
